// File: rtl/calc_unit_mc.sv
// ---------------------------------------------------------------------------
// calc_unit_mc
//
// Multi-cycle calculation stage for a small processor datapath. Selects the
// ALU operands (PC / A / zero on side A; B / PC increment / imm / shifted imm
// on side B), executes one operation per accepted start request and registers
// the result together with Zero, negative and overflow flags for the
// multi-cycle control FSM.
//
// Single-cycle ops complete one clock after start. When the optional
// iterative multiplier is built in, op 111 runs a shift-add multiply that
// takes WIDTH clocks and holds busy for that whole time.
//
// Configuration macro:
//   CALC_MUL_EN  defined   : op 111 = iterative unsigned multiply (low WIDTH
//                            bits), busy asserted for WIDTH clocks.
//                undefined : no multiplier; op 111 completes in one clock with
//                            result 0 (Zero=1, negative=0, overflow=0); busy
//                            is constant 0.
//
// Parameters:
//   WIDTH      datapath width in bits (>=4, power of 2)
//   PC_INC     constant used as operand B when ALUSrcB=01
//   IMM_SHIFT  left shift applied to imm when ALUSrcB=11
//
// Ports:
//   clk              in   rising-edge clock
//   reset            in   synchronous, active-high reset
//   start            in   operation request, accepted only while busy=0
//   input_ALUOp      in   [2:0] operation code
//   input_ALUSrcA    in   [1:0] 00 PC, 01 zero, 10 A, 11 zero
//   input_ALUSrcB    in   [1:0] 00 B, 01 PC_INC, 10 imm, 11 imm<<IMM_SHIFT
//   input_A          in   [WIDTH-1:0] register A
//   input_B          in   [WIDTH-1:0] register B
//   input_PC         in   [WIDTH-1:0] program counter
//   input_imm        in   [WIDTH-1:0] sign-extended immediate
//   output_ALU       out  [WIDTH-1:0] registered result
//   output_Zero      out  result == 0
//   output_negative  out  result MSB
//   output_overflow  out  signed overflow of ADD/SUB, 0 otherwise
//   busy             out  multi-cycle operation in progress
//   done             out  one-cycle pulse, result and flags just updated
// ---------------------------------------------------------------------------
module calc_unit_mc #(
    parameter int WIDTH     = 16,
    parameter int PC_INC    = 2,
    parameter int IMM_SHIFT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       input_ALUOp,
    input  logic [1:0]       input_ALUSrcA,
    input  logic [1:0]       input_ALUSrcB,
    input  logic [WIDTH-1:0] input_A,
    input  logic [WIDTH-1:0] input_B,
    input  logic [WIDTH-1:0] input_PC,
    input  logic [WIDTH-1:0] input_imm,
    output logic [WIDTH-1:0] output_ALU,
    output logic             output_Zero,
    output logic             output_negative,
    output logic             output_overflow,
    output logic             busy,
    output logic             done
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRA = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    // -----------------------------------------------------------------------
    // Operand selection
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        op_a = '0;
        unique case (input_ALUSrcA)
            2'b00:   op_a = input_PC;
            2'b10:   op_a = input_A;
            default: op_a = '0;
        endcase
    end

    always_comb begin
        op_b = '0;
        unique case (input_ALUSrcB)
            2'b00: op_b = input_B;
            2'b01: op_b = WIDTH'(PC_INC);
            2'b10: op_b = input_imm;
            2'b11: op_b = input_imm << IMM_SHIFT;
        endcase
    end

    // -----------------------------------------------------------------------
    // Single-cycle ALU: next result and overflow for every op except the
    // iterative multiply (which yields 0 here, matching the no-multiplier
    // build).
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;

    assign sum   = op_a + op_b;
    assign diff  = op_a - op_b;
    assign shamt = op_b[SHW-1:0];

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        unique case (input_ALUOp)
            OP_AND: res_d = op_a & op_b;
            OP_ADD: begin
                res_d = sum;
                // Operands agree in sign but the sum does not.
                ovf_d = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                res_d = diff;
                // Operands differ in sign and the difference left a's sign.
                ovf_d = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
            end
            OP_OR:  res_d = op_a | op_b;
            OP_XOR: res_d = op_a ^ op_b;
            OP_SLL: res_d = op_a << shamt;
            OP_SRA: res_d = $signed(op_a) >>> shamt;
            OP_MUL: res_d = '0;
        endcase
    end

`ifdef CALC_MUL_EN
    // -----------------------------------------------------------------------
    // Control FSM with iterative shift-add multiplier.
    // The multiplicand shifts left and the multiplier shifts right each
    // step; after WIDTH steps the accumulator holds the low WIDTH bits of
    // the product.
    // -----------------------------------------------------------------------
    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    state_e           state_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_d;

    // Accumulator after the current step, also the final product on the
    // last step.
    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the multiplier working registers are reset too; it costs
            // little here and keeps simulation free of X after reset.
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            acc_q           <= '0;
            mcand_q         <= '0;
            mplier_q        <= '0;
            output_ALU      <= '0;
            output_Zero     <= 1'b0;
            output_negative <= 1'b0;
            output_overflow <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (input_ALUOp == OP_MUL) begin
                            // Latch operands so input changes during the
                            // multiply have no effect.
                            acc_q    <= '0;
                            mcand_q  <= op_a;
                            mplier_q <= op_b;
                            cnt_q    <= '0;
                            busy     <= 1'b1;
                            state_q  <= S_MUL;
                        end else begin
                            output_ALU      <= res_d;
                            output_Zero     <= ~|res_d;
                            output_negative <= res_d[MSB];
                            output_overflow <= ovf_d;
                            done            <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + SHW'(1);
                    if (cnt_q == SHW'(WIDTH - 1)) begin
                        output_ALU      <= acc_d;
                        output_Zero     <= ~|acc_d;
                        output_negative <= acc_d[MSB];
                        output_overflow <= 1'b0;
                        done            <= 1'b1;
                        busy            <= 1'b0;
                        state_q         <= S_IDLE;
                    end
                end
            endcase
        end
    end
`else
    // -----------------------------------------------------------------------
    // No multiplier: every op, including 111, completes in one clock.
    // -----------------------------------------------------------------------
    assign busy = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            output_ALU      <= '0;
            output_Zero     <= 1'b0;
            output_negative <= 1'b0;
            output_overflow <= 1'b0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                output_ALU      <= res_d;
                output_Zero     <= ~|res_d;
                output_negative <= res_d[MSB];
                output_overflow <= ovf_d;
                done            <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_calc_unit_mc.sv
module tb_calc_unit_mc;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   alu_op;
    logic [1:0]   src_a;
    logic [1:0]   src_b;
    logic [W-1:0] in_a, in_b, in_pc, in_imm;
    logic [W-1:0] output_ALU;
    logic         output_Zero, output_negative, output_overflow, busy, done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    calc_unit_mc #(.WIDTH(W), .PC_INC(2), .IMM_SHIFT(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .input_ALUOp    (alu_op),
        .input_ALUSrcA  (src_a),
        .input_ALUSrcB  (src_b),
        .input_A        (in_a),
        .input_B        (in_b),
        .input_PC       (in_pc),
        .input_imm      (in_imm),
        .output_ALU     (output_ALU),
        .output_Zero    (output_Zero),
        .output_negative(output_negative),
        .output_overflow(output_overflow),
        .busy           (busy),
        .done           (done)
    );

    initial begin
        #1_000_000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: operand table and op semantics computed with plain
    // integer arithmetic.
    task automatic model(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] pc, input logic [W-1:0] imm,
                         output logic [W-1:0] r, output logic z, output logic n,
                         output logic v);
        logic [W-1:0] x, y;
        int sx, sy, s;
        x = (sa == 2'd0) ? pc : (sa == 2'd2) ? a : '0;
        case (sb)
            2'd0:    y = b;
            2'd1:    y = 16'd2;
            2'd2:    y = imm;
            default: y = 16'((32'(imm) * 2) % 65536);
        endcase
        sx = int'($signed(x));
        sy = int'($signed(y));
        v = 1'b0;
        case (op)
            3'd0: r = x & y;
            3'd1: begin s = sx + sy; r = 16'(s); v = (s > 32767) || (s < -32768); end
            3'd2: begin s = sx - sy; r = 16'(s); v = (s > 32767) || (s < -32768); end
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = 16'((32'(x) * (32'd1 << (y % 16))) % 65536);
            3'd6: r = 16'(sx >>> (y % 16));
`ifdef CALC_MUL_EN
            default: r = 16'((32'(x) * 32'(y)) % 65536);
`else
            default: r = '0;
`endif
        endcase
        z = (r == 0);
        n = r[W-1];
    endtask

    task automatic drive(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] pc, input logic [W-1:0] imm);
        alu_op = op; src_a = sa; src_b = sb;
        in_a = a; in_b = b; in_pc = pc; in_imm = imm;
    endtask

    // Single-cycle op: start for one clock, expect done and result one
    // clock later, then done drops and the result holds.
    task automatic run_single(input string tag, input logic [2:0] op,
                              input logic [1:0] sa, input logic [1:0] sb,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] pc, input logic [W-1:0] imm);
        logic [W-1:0] er;
        logic ez, en, ev;
        model(op, sa, sb, a, b, pc, imm, er, ez, en, ev);
        @(negedge clk);
        drive(op, sa, sb, a, b, pc, imm);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done"}, 32'(done), 32'(1));
        check({tag, "_alu"},  32'(output_ALU), 32'(er));
        check({tag, "_z"},    32'(output_Zero), 32'(ez));
        check({tag, "_n"},    32'(output_negative), 32'(en));
        check({tag, "_v"},    32'(output_overflow), 32'(ev));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        drive(3'($urandom), 2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'(0));
        check({tag, "_hold"}, 32'(output_ALU), 32'(er));
    endtask

`ifdef CALC_MUL_EN
    // Multiply: busy for W clocks, a start mid-way is ignored and input
    // changes after launch have no effect.
    task automatic run_mul(input string tag, input logic [1:0] sa, input logic [1:0] sb,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] pc, input logic [W-1:0] imm);
        logic [W-1:0] er;
        logic ez, en, ev;
        int k;
        bit got;
        int busy_low;
        model(3'd7, sa, sb, a, b, pc, imm, er, ez, en, ev);
        @(negedge clk);
        drive(3'd7, sa, sb, a, b, pc, imm);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_on"}, 32'(busy), 32'(1));
        check({tag, "_no_done"}, 32'(done), 32'(0));
        k = 0;
        got = 1'b0;
        busy_low = 0;
        while (!got && k < W + 4) begin
            if (k == 2) begin
                drive(3'd1, 2'd2, 2'd0, 16'($urandom), 16'($urandom), 16'($urandom),
                      16'($urandom));
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
            if (done) got = 1'b1;
            else if (busy !== 1'b1) busy_low++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(k), 32'(W));
        check({tag, "_busy_held"}, 32'(busy_low), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(1));
        check({tag, "_alu"}, 32'(output_ALU), 32'(er));
        check({tag, "_z"}, 32'(output_Zero), 32'(ez));
        check({tag, "_n"}, 32'(output_negative), 32'(en));
        check({tag, "_v"}, 32'(output_overflow), 32'(0));
        check({tag, "_busy_off"}, 32'(busy), 32'(0));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'(0));
        check({tag, "_hold"}, 32'(output_ALU), 32'(er));
    endtask
`endif

    task automatic check_reset_state(input string tag);
        check({tag, "_alu"},  32'(output_ALU), 32'(0));
        check({tag, "_z"},    32'(output_Zero), 32'(0));
        check({tag, "_n"},    32'(output_negative), 32'(0));
        check({tag, "_v"},    32'(output_overflow), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
    endtask

    initial begin
        logic [W-1:0] e1, e2;
        logic ez, en, ev;
        int dones;

        reset = 1'b1;
        start = 1'b0;
        drive(3'd0, 2'd0, 2'd0, '0, '0, '0, '0);
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;

        // Directed cases with literal expected values.
        run_single("add", 3'd1, 2'd2, 2'd0, 16'h1234, 16'h5678, 16'h0, 16'h0);
        check("add_lit", 32'(output_ALU), 32'h68AC);
        run_single("sub_imm", 3'd2, 2'd2, 2'd2, 16'hABCD, 16'h0, 16'h0, 16'h1111);
        check("sub_imm_lit", 32'(output_ALU), 32'h9ABC);
        check("sub_imm_n", 32'(output_negative), 32'(1));
        run_single("sub_zero", 3'd2, 2'd2, 2'd0, 16'h5555, 16'h5555, 16'h0, 16'h0);
        check("sub_zero_z", 32'(output_Zero), 32'(1));
        run_single("pc_inc", 3'd1, 2'd0, 2'd1, 16'h0, 16'h0, 16'h1234, 16'h0);
        check("pc_inc_lit", 32'(output_ALU), 32'h1236);
        run_single("pc_br", 3'd1, 2'd0, 2'd3, 16'h0, 16'h0, 16'h1234, 16'h0010);
        check("pc_br_lit", 32'(output_ALU), 32'h1254);
        run_single("add_ovf", 3'd1, 2'd2, 2'd0, 16'h7FFF, 16'h0001, 16'h0, 16'h0);
        check("add_ovf_lit", 32'(output_ALU), 32'h8000);
        check("add_ovf_v", 32'(output_overflow), 32'(1));
        run_single("sub_ovf", 3'd2, 2'd2, 2'd0, 16'h8000, 16'h0001, 16'h0, 16'h0);
        check("sub_ovf_lit", 32'(output_ALU), 32'h7FFF);
        check("sub_ovf_v", 32'(output_overflow), 32'(1));
        run_single("sra", 3'd6, 2'd2, 2'd0, 16'h8F00, 16'h0014, 16'h0, 16'h0);
        run_single("sll", 3'd5, 2'd2, 2'd0, 16'h00F3, 16'h001F, 16'h0, 16'h0);

        // Multiply / op 111.
`ifdef CALC_MUL_EN
        run_mul("mul", 2'd2, 2'd0, 16'h0012, 16'h0034, 16'h0, 16'h0);
        check("mul_lit", 32'(output_ALU), 32'h03A8);
`else
        run_single("mul_off", 3'd7, 2'd2, 2'd0, 16'h0012, 16'h0034, 16'h0, 16'h0);
        check("mul_off_z", 32'(output_Zero), 32'(1));
`endif

        // Back-to-back starts in consecutive cycles.
        @(negedge clk);
        drive(3'd1, 2'd2, 2'd0, 16'h0F0F, 16'h1111, 16'h0, 16'h0);
        model(3'd1, 2'd2, 2'd0, 16'h0F0F, 16'h1111, 16'h0, 16'h0, e1, ez, en, ev);
        start = 1'b1;
        @(negedge clk);
        check("b2b_done1", 32'(done), 32'(1));
        check("b2b_alu1", 32'(output_ALU), 32'(e1));
        drive(3'd4, 2'd2, 2'd0, 16'hFFFF, 16'h00FF, 16'h0, 16'h0);
        model(3'd4, 2'd2, 2'd0, 16'hFFFF, 16'h00FF, 16'h0, 16'h0, e2, ez, en, ev);
        @(negedge clk);
        start = 1'b0;
        check("b2b_done2", 32'(done), 32'(1));
        check("b2b_alu2", 32'(output_ALU), 32'(e2));
        check("b2b_n2", 32'(output_negative), 32'(en));
        @(negedge clk);
        check("b2b_pulse", 32'(done), 32'(0));

        // Randomized ops against the model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(7, 0));
`ifdef CALC_MUL_EN
            if (op == 3'd7)
                run_mul("rnd_mul", 2'($urandom), 2'($urandom), 16'($urandom),
                        16'($urandom), 16'($urandom), 16'($urandom));
            else
`endif
                run_single("rnd", op, 2'($urandom), 2'($urandom), 16'($urandom),
                           16'($urandom), 16'($urandom), 16'($urandom));
        end

        // Reset in the middle of activity.
        run_single("pre_rst", 3'd3, 2'd2, 2'd0, 16'hA5A5, 16'h0F00, 16'h0, 16'h0);
`ifdef CALC_MUL_EN
        @(negedge clk);
        drive(3'd7, 2'd2, 2'd0, 16'h0012, 16'h0034, 16'h0, 16'h0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_mul_busy", 32'(busy), 32'(1));
`endif
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("mid_rst");
        reset = 1'b0;
        dones = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("post_rst_no_done", 32'(dones), 32'(0));
        check("post_rst_alu", 32'(output_ALU), 32'(0));
        run_single("post_rst_add", 3'd1, 2'd2, 2'd0, 16'h1234, 16'h5678, 16'h0, 16'h0);
        check("post_rst_add_lit", 32'(output_ALU), 32'h68AC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
